// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 4-bit processor: PC, 4x4 register bank,
// synchronous program ROM fetch, ULA operand drive, writeback and display result.
module instr_sequencer #(
    parameter int PC_W     = 4,
    parameter int PROG_LEN = 16,
    parameter int ULA_LAT  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            step,
    input  logic [3:0]      sw_data,
    output logic [PC_W-1:0] rom_addr,
    input  logic [7:0]      rom_data,
    output logic [3:0]      ula_op,
    output logic [3:0]      ula_a,
    output logic [3:0]      ula_b,
    input  logic [7:0]      ula_out,
    output logic [7:0]      result,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      opcode_dbg,
    output logic            busy,
    output logic            halted,
    input  logic [1:0]      dbg_sel,
    output logic [3:0]      dbg_reg
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_ALU_MAX = 4'hC;
    localparam logic [3:0] OP_OUT     = 4'hD;
    localparam logic [3:0] OP_HALT    = 4'hE;
    localparam logic [3:0] OP_LDI     = 4'hF;

    localparam int                CNT_W     = (ULA_LAT > 1) ? $clog2(ULA_LAT) : 1;
    localparam logic [CNT_W-1:0]  EXEC_LAST = CNT_W'(ULA_LAT - 1);
    localparam logic [PC_W-1:0]   PC_LAST   = PC_W'(PROG_LEN - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [7:0]        r_ir;
    logic [3:0]        r_bank [4];
    logic [CNT_W-1:0]  r_exec_cnt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_rom_addr;
    logic [3:0]        r_ula_op;
    logic [3:0]        r_ula_a;
    logic [3:0]        r_ula_b;
    logic [7:0]        r_result;
    logic [3:0]        r_opcode_dbg;

    logic [3:0]        w_op;
    logic [1:0]        w_rd;
    logic [1:0]        w_rs;
    logic              w_is_alu;
    logic              w_start;
    logic [PC_W-1:0]   w_pc_next;

    assign w_op      = r_ir[7:4];
    assign w_rd      = r_ir[3:2];
    assign w_rs      = r_ir[1:0];
    assign w_is_alu  = (w_op <= OP_ALU_MAX);
    assign w_start   = run || step;
    assign w_pc_next = (r_pc == PC_LAST) ? '0 : r_pc + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    // NOTE: every branch starts from the default below, so no path leaves
    // w_next_state unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_WAIT;
            S_WAIT:   w_next_state = S_DECODE;
            S_DECODE: begin
                if (w_op == OP_HALT) w_next_state = S_HALT;
                else if (w_is_alu)   w_next_state = S_EXEC;
                else                 w_next_state = S_WB;
            end
            S_EXEC:   if (r_exec_cnt == EXEC_LAST) w_next_state = S_WB;
            S_WB:     w_next_state = run ? S_FETCH : S_IDLE;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state elements use non-blocking assignments so every register
    // samples pre-edge values; that is what makes rd==rs read the old operand.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc         <= '0;
            r_rom_addr   <= '0;
            r_ula_op     <= '0;
            r_ula_a      <= '0;
            r_ula_b      <= '0;
            r_result     <= '0;
            r_opcode_dbg <= '0;
            r_ir         <= '0;
            r_exec_cnt   <= '0;
            // NOTE: the bank is four flops, not a RAM, so it can and must clear on reset.
            for (int i = 0; i < 4; i++) r_bank[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) r_rom_addr <= r_pc;
                S_WAIT: begin
                    r_ir         <= rom_data;
                    r_opcode_dbg <= rom_data[7:4];
                end
                S_DECODE: begin
                    r_exec_cnt <= '0;
                    if (w_is_alu) begin
                        r_ula_op <= w_op;
                        r_ula_a  <= r_bank[w_rd];
                        r_ula_b  <= r_bank[w_rs];
                    end
                end
                S_EXEC: r_exec_cnt <= r_exec_cnt + 1'b1;
                S_WB: begin
                    if (w_is_alu) begin
                        r_bank[w_rd] <= ula_out[3:0];
                        r_result     <= ula_out;
                    end else if (w_op == OP_LDI) begin
                        r_bank[w_rd] <= sw_data;
                    end else if (w_op == OP_OUT) begin
                        r_result <= {r_bank[w_rd], r_bank[w_rs]};
                    end
                    r_pc <= w_pc_next;
                    if (run) r_rom_addr <= w_pc_next;
                end
                default: ;
            endcase
        end
    end

    assign rom_addr   = r_rom_addr;
    assign ula_op     = r_ula_op;
    assign ula_a      = r_ula_a;
    assign ula_b      = r_ula_b;
    assign result     = r_result;
    assign pc         = r_pc;
    assign opcode_dbg = r_opcode_dbg;
    assign busy       = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted     = (r_state == S_HALT);
    assign dbg_reg    = r_bank[dbg_sel];

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer: ROM and ULA models plus an
// architectural (instruction-level) reference model of the register machine.
module tb_instr_sequencer;

    localparam int PC_W     = 4;
    localparam int PROG_LEN = 16;
    localparam int ULA_LAT  = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            run = 1'b0;
    logic            step = 1'b0;
    logic [3:0]      sw_data = '0;
    logic [PC_W-1:0] rom_addr;
    logic [7:0]      rom_data = '0;
    logic [3:0]      ula_op, ula_a, ula_b;
    logic [7:0]      ula_out = '0;
    logic [7:0]      result;
    logic [PC_W-1:0] pc;
    logic [3:0]      opcode_dbg;
    logic            busy, halted;
    logic [1:0]      dbg_sel = '0;
    logic [3:0]      dbg_reg;

    logic [7:0] rom [PROG_LEN];

    int n_checks = 0;
    int n_errors = 0;

    // architectural model
    logic [3:0]      m_r [4];
    logic [7:0]      m_result;
    logic [PC_W-1:0] m_pc;
    logic [3:0]      m_opc;
    logic            m_halted;

    instr_sequencer #(.PC_W(PC_W), .PROG_LEN(PROG_LEN), .ULA_LAT(ULA_LAT)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .sw_data(sw_data),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ula_op(ula_op), .ula_a(ula_a), .ula_b(ula_b), .ula_out(ula_out),
        .result(result), .pc(pc), .opcode_dbg(opcode_dbg),
        .busy(busy), .halted(halted), .dbg_sel(dbg_sel), .dbg_reg(dbg_reg)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ula_fn(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        logic [7:0] ea, eb;
        ea = {4'h0, a};
        eb = {4'h0, b};
        case (op)
            4'h0: return ea + eb;
            4'h1: return ea - eb;
            4'h2: return ea & eb;
            4'h3: return ea | eb;
            4'h4: return ea ^ eb;
            4'h5: return {4'h0, ~a};
            4'h6: return ea << 1;
            4'h7: return ea >> 1;
            4'h8: return ea * eb;
            4'h9: return ea;
            4'hA: return eb;
            4'hB: return (a == b) ? 8'd1 : 8'd0;
            4'hC: return (a < b) ? 8'd1 : 8'd0;
            default: return 8'h00;
        endcase
    endfunction

    // synchronous ROM and single-stage ULA
    always @(posedge clk) rom_data <= rom[rom_addr];
    always @(posedge clk) ula_out <= ula_fn(ula_op, ula_a, ula_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        m_result = '0;
        m_pc     = '0;
        m_opc    = '0;
        m_halted = 1'b0;
    endtask

    task automatic model_exec(input logic [7:0] instr, input logic [3:0] sw);
        logic [3:0] op;
        logic [1:0] rd, rs;
        logic [7:0] y;
        op = instr[7:4];
        rd = instr[3:2];
        rs = instr[1:0];
        m_opc = op;
        if (op == 4'hE) begin
            m_halted = 1'b1;
            return;
        end
        if (op <= 4'hC) begin
            y        = ula_fn(op, m_r[rd], m_r[rs]);
            m_r[rd]  = y[3:0];
            m_result = y;
        end else if (op == 4'hD) begin
            m_result = {m_r[rd], m_r[rs]};
        end else begin
            m_r[rd] = sw;
        end
        m_pc = PC_W'((int'(m_pc) + 1) % PROG_LEN);
    endtask

    task automatic read_reg(input int i, output logic [3:0] v);
        dbg_sel = 2'(i);
        #1;
        v = dbg_reg;
    endtask

    task automatic compare_state(input string tag);
        logic [3:0] v;
        check({tag, ".pc"}, 32'(pc), 32'(m_pc));
        check({tag, ".result"}, 32'(result), 32'(m_result));
        check({tag, ".opcode"}, 32'(opcode_dbg), 32'(m_opc));
        check({tag, ".halted"}, 32'(halted), 32'(m_halted));
        check({tag, ".busy"}, 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            check($sformatf("%s.R%0d", tag, i), 32'(v), 32'(m_r[i]));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // One stepped instruction; optional extra step pulses while busy must be ignored.
    task automatic step_instr(input string tag, input logic [3:0] sw, input bit extra);
        logic [7:0] instr;
        logic [7:0] old_res;
        int n, exp_n;
        bit early;
        instr   = rom[m_pc];
        sw_data = sw;
        old_res = result;
        early   = 1'b0;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        exp_n = (instr[7:4] <= 4'hC) ? 4 + ULA_LAT : (instr[7:4] == 4'hE) ? 3 : 4;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
            step = extra && (n == 1 || n == 2);
            if (busy && result !== old_res) early = 1'b1;
        end
        step = 1'b0;
        check({tag, ".latency"}, 32'(n), 32'(exp_n));
        check({tag, ".early_wb"}, 32'(early), 32'd0);
        model_exec(instr, sw);
        compare_state(tag);
    endtask

    initial begin
        logic [3:0] v;
        logic [PC_W-1:0] prev;
        int n;

        for (int i = 0; i < PROG_LEN; i++) rom[i] = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // reset state
        compare_state("reset");
        check("reset.rom_addr", 32'(rom_addr), 32'd0);
        check("reset.ula_op", 32'(ula_op), 32'd0);
        check("reset.ula_ab", 32'({ula_a, ula_b}), 32'd0);

        // LDI R0,5 ; LDI R1,3 ; ADD R0,R1 (with extra steps during the ADD)
        rom[0] = 8'hF0;
        rom[1] = 8'hF4;
        rom[2] = 8'h01;
        step_instr("ldi0", 4'h5, 1'b0);
        step_instr("ldi1", 4'h3, 1'b0);
        step_instr("add", 4'h0, 1'b1);
        read_reg(0, v);
        check("add.R0_const", 32'(v), 32'h8);
        check("add.result_const", 32'(result), 32'h08);
        check("add.pc_const", 32'(pc), 32'd3);

        // OUT of preloaded registers
        rom[3] = 8'hF0;
        rom[4] = 8'hF4;
        rom[5] = 8'hD1;
        step_instr("ldiA", 4'hA, 1'b0);
        step_instr("ldi3", 4'h3, 1'b0);
        step_instr("out", 4'h0, 1'b0);
        check("out.result_const", 32'(result), 32'hA3);
        read_reg(0, v);
        check("out.dbg0", 32'(v), 32'hA);

        // random programs (no HALT), crosses the PC wrap several times
        for (int i = 0; i < PROG_LEN; i++) begin
            rom[i] = 8'($urandom_range(0, 255));
            if (rom[i][7:4] == 4'hE) rom[i][7:4] = 4'hD;
        end
        for (int k = 0; k < 40; k++)
            step_instr($sformatf("rnd%0d", k), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)));

        // reset in the middle of EXEC
        rom[m_pc] = 8'h05;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        check("midexec.busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        compare_state("midexec");

        // free run over all-LDI ROM: one instruction every 4 cycles, PC wraps
        for (int i = 0; i < PROG_LEN; i++) rom[i] = 8'hF0;
        sw_data = 4'h7;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        prev = pc;
        for (int k = 0; k < PROG_LEN + 1; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (pc == prev && n < 12);
            check($sformatf("run%0d.gap", k), 32'(n), 32'd4);
            check($sformatf("run%0d.pc", k), 32'(pc), 32'((int'(prev) + 1) % PROG_LEN));
            prev = PC_W'((int'(prev) + 1) % PROG_LEN);
        end
        run = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("runstop.busy", 32'(busy), 32'd0);
        check("runstop.pc", 32'(pc), 32'((int'(prev) + 1) % PROG_LEN));
        repeat (5) @(negedge clk);
        check("runstop.pc_hold", 32'(pc), 32'((int'(prev) + 1) % PROG_LEN));
        read_reg(0, v);
        check("runstop.R0", 32'(v), 32'h7);

        // HALT: freezes until reset
        m_pc   = pc;
        m_r[0] = 4'h7;
        m_opc  = 4'hF;
        m_result = result;
        rom[m_pc] = 8'hE0;
        step_instr("halt", 4'h0, 1'b0);
        prev = pc;
        run  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            step = ~step;
        end
        run  = 1'b0;
        step = 1'b0;
        @(negedge clk);
        check("halt.pc_frozen", 32'(pc), 32'(prev));
        check("halt.still", 32'(halted), 32'd1);
        check("halt.busy", 32'(busy), 32'd0);
        apply_reset();
        compare_state("halt_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Fetch/decode/execute controller for the 4-bit processor: replaces direct execution from program memory with a RISC-style register model. Holds the PC and a 4x4-bit register bank, fetches 8-bit instructions from the synchronous program ROM, and drives the ULA operands/opcode. It then writes results back to the bank and to a display result register. It runs either free-running or one instruction per step pulse.

Parameters:
PC_W, 4, program counter / ROM address width
PROG_LEN, 16, number of ROM words; PC wraps to 0 after PROG_LEN-1
ULA_LAT, 1, ULA output latency in clocks after its inputs are registered (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
run  in  1  level; 1 = free-run back-to-back instructions
step  in  1  single-cycle pulse; starts one instruction when in IDLE (debounced/edge-detected upstream)
sw_data  in  4  immediate source for LDI
rom_addr  out  PC_W  program ROM address (registered)
rom_data  in  8  program ROM data, valid 1 cycle after rom_addr
ula_op  out  4  ULA opcode (registered)
ula_a  out  4  ULA operand A (registered)
ula_b  out  4  ULA operand B (registered)
ula_out  in  8  ULA result
result  out  8  last ALU/OUT result for 7-seg display
pc  out  PC_W  current PC
opcode_dbg  out  4  opcode of last decoded instruction (LEDs)
busy  out  1  1 in any state except IDLE and HALT
halted  out  1  1 in HALT
dbg_sel  in  2  register bank view select
dbg_reg  out  4  R[dbg_sel], combinational read

Behaviour:
- Reset (rst=0 at posedge, overrides everything, including mid-instruction): state=IDLE. pc, rom_addr, ula_op, ula_a, ula_b, result, opcode_dbg, R0-R3 all 0. busy=0, halted=0.
- Instruction: [7:4] opcode, [3:2] rd (also operand A), [1:0] rs (operand B).
- 0x0-0xC: ALU op, ula_op=opcode. 0xD: OUT. 0xE: HALT. 0xF: LDI.
- States: IDLE, FETCH, WAIT, DECODE, EXEC, WB, HALT.
- IDLE: run=1 or step=1 -> FETCH, rom_addr<=pc. Otherwise stay.
- FETCH -> WAIT (ROM samples address).
- WAIT: at the edge leaving WAIT, IR<=rom_data and opcode_dbg<=rom_data[7:4]; -> DECODE.
- DECODE:
  - ALU: ula_a<=R[rd], ula_b<=R[rs], ula_op<=op; -> EXEC.
  - LDI, OUT: -> WB.
  - HALT: -> HALT.
- EXEC: stays exactly ULA_LAT cycles (internal counter), then -> WB.
- WB:
  - ALU: R[rd]<=ula_out[3:0], result<=ula_out.
  - LDI: R[rd]<=sw_data, sampled at the WB edge; result unchanged.
  - OUT: result<={R[rd],R[rs]}.
  - In all cases pc<=(pc==PROG_LEN-1)?0:pc+1.
  - Next state: run=1 -> FETCH (rom_addr<=next pc); else -> IDLE.
- HALT: outputs frozen, step/run ignored; exits only via reset.
- Latency, measured from the IDLE edge that accepts the start:
  - ALU instruction: writeback at edge 4+ULA_LAT (5 for default).
  - LDI/OUT: writeback at edge 4.
  - HALT: halted=1 after edge 3.
- step while busy: ignored, not queued.
- step and run both high: a single start.
- run deasserted mid-instruction: current instruction completes, then IDLE.
- rd==rs legal: the operand is read in DECODE, before writeback.
- PC wrap: after the instruction at PROG_LEN-1, pc=0.
- Register bank writes occur only in WB.

Test Plan:
- Reset mid-EXEC (rst=0 one edge) -> state IDLE, pc=0, R0-R3=0, result=0x00, busy=0 next cycle.
- ROM {0xF0, 0xF4, 0x01}, sw_data=5 for step 1 then 3, ULA model op0=a+b, 3 step pulses -> R0=5, R1=3, then R0=8 and result=0x08. ADD writeback occurs exactly 5 edges after its step is accepted; pc=3.
- Extra step pulses during busy in the ADD above -> ignored: exactly one instruction executed, pc advances by 1.
- run=1, ROM all 0xF0 with PROG_LEN=16 -> pc sequence 0..15,0 with one LDI every 4 cycles. Drop run -> stops after the current instruction, busy=0.
- ROM {0xD1} with R0=0xA, R1=0x3 preloaded via LDI -> result=0xA3; dbg_sel=0 -> dbg_reg=0xA.
- ROM word 0xE0 -> halted=1 3 edges after start; further step/run produce no pc change until rst=0.
